// File: rtl/uart_rx_buffer_if.sv
// AXI4-Lite read channel between the receive buffer (master) and the UART
// register block (slave).
interface uart_rx_buffer_if;
  logic [31:0] uart_araddr;
  logic        uart_arvalid;
  logic        uart_arready;
  logic [31:0] uart_rdata;
  logic [1:0]  uart_rresp;
  logic        uart_rvalid;
  logic        uart_rready;

  modport master (
    output uart_araddr, uart_arvalid, uart_rready,
    input  uart_arready, uart_rdata, uart_rresp, uart_rvalid
  );

  modport slave (
    input  uart_araddr, uart_arvalid, uart_rready,
    output uart_arready, uart_rdata, uart_rresp, uart_rvalid
  );
endinterface

// File: rtl/uart_rx_buffer.sv
// Assembles four received UART bytes into one 32-bit word by polling the
// status register and reading the RX FIFO register over AXI, one read at a time.
module uart_rx_buffer #(
  parameter logic [31:0] RX_ADDR   = 32'h0000_0000,
  parameter logic [31:0] STAT_ADDR = 32'h0000_0008,
  parameter int          RXV_BIT   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             renable,
  output logic             rdone,
  output logic [31:0]      rdata,
  uart_rx_buffer_if.master uart
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STAT_AR = 3'd1,
    STAT_R  = 3'd2,
    DATA_AR = 3'd3,
    DATA_R  = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] shift;

  // Poll/read sequencer; all AXI outputs are registered and change only on transitions.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      byte_cnt          <= 2'd0;
      shift             <= 32'h0000_0000;
      rdata             <= 32'h0000_0000;
      rdone             <= 1'b0;
      uart.uart_arvalid <= 1'b0;
      uart.uart_rready  <= 1'b0;
      uart.uart_araddr  <= STAT_ADDR;
    end else begin
      rdone <= 1'b0;
      case (state)
        IDLE: begin
          if (renable) begin
            byte_cnt          <= 2'd0;
            shift             <= 32'h0000_0000;
            uart.uart_araddr  <= STAT_ADDR;
            uart.uart_arvalid <= 1'b1;
            state             <= STAT_AR;
          end
        end
        STAT_AR: begin
          if (uart.uart_arvalid && uart.uart_arready) begin
            uart.uart_arvalid <= 1'b0;
            uart.uart_rready  <= 1'b1;
            state             <= STAT_R;
          end
        end
        STAT_R: begin
          if (uart.uart_rvalid && uart.uart_rready) begin
            uart.uart_rready  <= 1'b0;
            uart.uart_arvalid <= 1'b1;
            // Error responses and "no data yet" both mean: ask the status register again.
            if (uart.uart_rresp[1] || !uart.uart_rdata[RXV_BIT]) begin
              uart.uart_araddr <= STAT_ADDR;
              state            <= STAT_AR;
            end else begin
              uart.uart_araddr <= RX_ADDR;
              state            <= DATA_AR;
            end
          end
        end
        DATA_AR: begin
          if (uart.uart_arvalid && uart.uart_arready) begin
            uart.uart_arvalid <= 1'b0;
            uart.uart_rready  <= 1'b1;
            state             <= DATA_R;
          end
        end
        DATA_R: begin
          if (uart.uart_rvalid && uart.uart_rready) begin
            uart.uart_rready <= 1'b0;
            if (uart.uart_rresp[1]) begin
              // The FIFO did not pop on an error, so the same byte is re-read.
              uart.uart_araddr  <= RX_ADDR;
              uart.uart_arvalid <= 1'b1;
              state             <= DATA_AR;
            end else begin
              shift <= {shift[23:0], uart.uart_rdata[7:0]};
              if (byte_cnt == 2'd3) begin
                rdata <= {shift[23:0], uart.uart_rdata[7:0]};
                rdone <= 1'b1;
                state <= IDLE;
              end else begin
                byte_cnt          <= byte_cnt + 2'd1;
                uart.uart_araddr  <= STAT_ADDR;
                uart.uart_arvalid <= 1'b1;
                state             <= STAT_AR;
              end
            end
          end
        end
        default: begin
          uart.uart_arvalid <= 1'b0;
          uart.uart_rready  <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: behavioural UART register slave, word scoreboard,
// vector table plus hand sequences for latency, back-to-back and reset abort.
module tb_uart_rx_buffer;
  localparam logic [31:0] RX_A = 32'h0000_0000;
  localparam logic [31:0] ST_A = 32'h0000_0008;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        renable = 1'b0;
  logic        rdone;
  logic [31:0] rdata;

  uart_rx_buffer_if bus ();

  uart_rx_buffer #(.RX_ADDR(RX_A), .STAT_ADDR(ST_A), .RXV_BIT(0)) dut (
    .clk(clk), .rstn(rstn), .renable(renable), .rdone(rdone), .rdata(rdata), .uart(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rdone_cnt = 0;
  int viol = 0;
  logic [31:0] exp_q[$];

  // slave model configuration and counters
  logic [7:0] rx_q[$];
  int zeros = 0, zero_left = 0, err_at = -1, stall_left = 0;
  int n_rx = 0, n_stat = 0, n_other = 0;

  // UART register slave: one-cycle read latency, optional arready stall and SLVERR
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bus.uart_arready = 1'b1;
    bus.uart_rvalid  = 1'b0;
    bus.uart_rdata   = 32'h0000_0000;
    bus.uart_rresp   = 2'b00;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        bus.uart_rvalid <= 1'b0;
      end else begin
        if (bus.uart_rvalid && bus.uart_rready) bus.uart_rvalid <= 1'b0;
        if (bus.uart_arvalid && bus.uart_arready) begin
          d = 32'h0000_0000;
          r = 2'b00;
          if (bus.uart_araddr == ST_A) begin
            n_stat++;
            if (zero_left > 0) begin
              zero_left--;
            end else begin
              d = 32'h0000_00F1;
            end
          end else if (bus.uart_araddr == RX_A) begin
            if (n_rx == err_at) begin
              r = 2'b10;
              d = 32'h0000_00EE;
            end else begin
              if (rx_q.size() > 0) d = {24'h00_0000, rx_q.pop_front()};
              zero_left = zeros;
            end
            n_rx++;
          end else begin
            n_other++;
            r = 2'b11;
          end
          bus.uart_rvalid <= 1'b1;
          bus.uart_rdata  <= d;
          bus.uart_rresp  <= r;
        end
        if (bus.uart_arvalid && stall_left > 0) stall_left--;
      end
      bus.uart_arready <= (stall_left == 0);
    end
  end

  // Scoreboard on rdone plus handshake/output-stability monitor
  initial begin
    logic        p_rstn = 1'b0, p_arvalid = 1'b0, p_arready = 1'b0;
    logic [31:0] p_araddr = 32'h0000_0000, p_rdata = 32'h0000_0000, w;
    forever begin
      @(negedge clk);
      if (rstn && p_rstn) begin
        if (bus.uart_arvalid && bus.uart_rready) viol++;
        if (p_arvalid && !p_arready && (!bus.uart_arvalid || bus.uart_araddr != p_araddr)) viol++;
        if (!rdone && rdata != p_rdata) viol++;
      end
      if (rdone === 1'b1) begin
        rdone_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_rdone: rdata=%h with no word expected", rdata);
        end else begin
          w = exp_q.pop_front();
          if (rdata !== w) begin
            bad++;
            $display("FAIL sb_word: rdata=%h required=%h", rdata, w);
          end
        end
      end
      p_rstn    = rstn;
      p_arvalid = bus.uart_arvalid;
      p_arready = bus.uart_arready;
      p_araddr  = bus.uart_araddr;
      p_rdata   = rdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic setup_slave(input int z, input int e, input int s);
    rx_q.delete();
    zeros      = z;
    zero_left  = z;
    err_at     = e;
    stall_left = s;
    n_rx       = 0;
    n_stat     = 0;
    n_other    = 0;
  endtask

  task automatic pulse_renable();
    renable = 1'b1;
    @(negedge clk);
    renable = 1'b0;
  endtask

  task automatic wait_rdone(input int target, input string name);
    int n = 0;
    while (rdone_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rdone_cnt < target) begin
      bad++;
      $display("FAIL %s_timeout: rdone_count=%0d required=%0d", name, rdone_cnt, target);
    end
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          zeros;
    int          err_at;
    int          stall;
    bit          busy_req;
    logic [31:0] exp_word;
    int          exp_rx;
    int          exp_stat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, base, n;

    vecs[0] = '{8'h12, 8'h34, 8'h56, 8'h78, 0, -1, 0,  1'b0, 32'h1234_5678, 4, 4};
    vecs[1] = '{8'h12, 8'h34, 8'h56, 8'h78, 3, -1, 0,  1'b0, 32'h1234_5678, 4, 16};
    vecs[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 0, 1,  0,  1'b0, 32'h1234_5678, 5, 4};
    vecs[3] = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 1, 3,  10, 1'b1, 32'hA500_FF3C, 5, 8};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0,  0,  1'b0, 32'hFFFF_FFFF, 5, 4};
    vecs[5] = '{8'h00, 8'h80, 8'h01, 8'h7E, 2, -1, 10, 1'b1, 32'h0080_017E, 4, 12};

    repeat (3) @(negedge clk);
    check("reset_rdone",   {31'd0, rdone}, 32'd0);
    check("reset_rdata",   rdata, 32'h0000_0000);
    check("reset_arvalid", {31'd0, bus.uart_arvalid}, 32'd0);
    check("reset_rready",  {31'd0, bus.uart_rready}, 32'd0);
    check("reset_araddr",  bus.uart_araddr, ST_A);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // minimum latency: 16 edges from the renable-sampling edge to rdone
    setup_slave(0, -1, 0);
    rx_q.push_back(8'h12); rx_q.push_back(8'h34); rx_q.push_back(8'h56); rx_q.push_back(8'h78);
    exp_q.push_back(32'h1234_5678);
    pulse_renable();
    cyc = 0;
    while (rdone !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 32'd16);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      base = rdone_cnt;
      setup_slave(vecs[i].zeros, vecs[i].err_at, vecs[i].stall);
      rx_q.push_back(vecs[i].b0); rx_q.push_back(vecs[i].b1);
      rx_q.push_back(vecs[i].b2); rx_q.push_back(vecs[i].b3);
      exp_q.push_back(vecs[i].exp_word);
      pulse_renable();
      if (vecs[i].busy_req) begin
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_arvalid_stalled", i), {31'd0, bus.uart_arvalid}, 32'd1);
        check($sformatf("v%0d_araddr_stalled", i), bus.uart_araddr, ST_A);
        pulse_renable();
        repeat (2) @(negedge clk);
        pulse_renable();
      end
      wait_rdone(base + 1, $sformatf("v%0d", i));
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_rdone_count", i), rdone_cnt, base + 1);
      check($sformatf("v%0d_rx_reads", i), n_rx, vecs[i].exp_rx);
      check($sformatf("v%0d_stat_reads", i), n_stat, vecs[i].exp_stat);
      check($sformatf("v%0d_bad_addr", i), n_other, 32'd0);
    end

    // renable while rdone is high starts the next word immediately
    base = rdone_cnt;
    setup_slave(0, -1, 0);
    rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33); rx_q.push_back(8'h44);
    rx_q.push_back(8'h55); rx_q.push_back(8'h66); rx_q.push_back(8'h77); rx_q.push_back(8'h88);
    exp_q.push_back(32'h1122_3344);
    exp_q.push_back(32'h5566_7788);
    pulse_renable();
    n = 0;
    while (rdone !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    pulse_renable();
    wait_rdone(base + 2, "b2b");
    repeat (4) @(negedge clk);
    check("b2b_rdone_count", rdone_cnt, base + 2);
    check("b2b_rx_reads", n_rx, 32'd8);

    // reset after two bytes abandons the word
    base = rdone_cnt;
    setup_slave(0, -1, 0);
    rx_q.push_back(8'h12); rx_q.push_back(8'h34); rx_q.push_back(8'h56); rx_q.push_back(8'h78);
    pulse_renable();
    n = 0;
    while (n_rx < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("abort_two_bytes_read", n_rx, 32'd2);
    rstn = 1'b0;
    #1;
    check("abort_rdata_cleared", rdata, 32'h0000_0000);
    check("abort_arvalid", {31'd0, bus.uart_arvalid}, 32'd0);
    check("abort_rready", {31'd0, bus.uart_rready}, 32'd0);
    check("abort_araddr", bus.uart_araddr, ST_A);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_rdone", rdone_cnt, base);
    setup_slave(0, -1, 0);
    rx_q.push_back(8'hAA); rx_q.push_back(8'hBB); rx_q.push_back(8'hCC); rx_q.push_back(8'hDD);
    exp_q.push_back(32'hAABB_CCDD);
    pulse_renable();
    wait_rdone(base + 1, "after_abort");
    repeat (4) @(negedge clk);
    check("after_abort_rdone_count", rdone_cnt, base + 1);
    check("after_abort_rx_reads", n_rx, 32'd4);

    check("protocol_violations", viol, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL provide parameter RX_ADDR, default 32'h0, AXI address of the UART receive FIFO register.
REQ-002 SHALL provide parameter STAT_ADDR, default 32'h8, AXI address of the UART status register.
REQ-003 SHALL provide parameter RXV_BIT, default 0, bit index in the status word meaning "receive data valid".
REQ-004 SHALL provide: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL provide: rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide: renable  input  1  request to read one 32-bit word.
REQ-007 SHALL provide: rdone  output  1  one-cycle pulse, word complete.
REQ-008 SHALL provide: rdata  output  32  assembled word.
REQ-009 SHALL provide: uart_araddr  output  32  AXI read address.
REQ-010 SHALL provide: uart_arvalid  output  1 and uart_arready  input  1, AXI read-address handshake.
REQ-011 SHALL provide: uart_rdata  input  32, uart_rresp  input  2, uart_rvalid  input  1, uart_rready  output  1, AXI read-data channel.

Function
REQ-012 SHALL implement states IDLE, STAT_AR, STAT_R, DATA_AR, DATA_R.
REQ-013 IDLE: renable=1 -> clear 2-bit byte counter, clear shift register, go to STAT_AR; renable=0 -> stay.
REQ-014 SHALL ignore renable in every state other than IDLE; no request is queued.
REQ-015 STAT_AR: drive uart_araddr=STAT_ADDR, uart_arvalid=1; on arvalid&&arready, drop arvalid, go to STAT_R.
REQ-016 STAT_R: uart_rready=1; on rvalid&&rready, drop rready, then:
 - rresp[1]=1 -> STAT_AR (retry);
 - uart_rdata[RXV_BIT]=0 -> STAT_AR (poll again);
 - else -> DATA_AR.
REQ-017 DATA_AR: drive uart_araddr=RX_ADDR, uart_arvalid=1; on arvalid&&arready, drop arvalid, go to DATA_R.
REQ-018 DATA_R: uart_rready=1; on rvalid&&rready, drop rready; rresp[1]=1 -> DATA_AR (retry, byte not consumed).
REQ-019 DATA_R good response: shift register <= {shift[23:0], uart_rdata[7:0]}; first byte received ends in [31:24], fourth in [7:0].
REQ-020 DATA_R good response, counter<3 -> counter+1, go to STAT_AR.
REQ-021 DATA_R good response, counter==3 -> rdata <= completed word, rdone=1 for exactly one cycle, go to IDLE.
REQ-022 rdata SHALL hold its value until the next completion; only changes together with an rdone pulse.
REQ-023 arvalid SHALL NOT drop before arready is seen; at most one AXI read outstanding; arvalid and rready never both high.
REQ-024 rdone asserts the cycle after the accepting rvalid edge; earliest rdone is 16 handshake cycles after renable with arready/rvalid tied high.
REQ-025 renable in the same cycle rdone is high (FSM in IDLE) SHALL be accepted.

Reset
REQ-026 rstn=0 SHALL immediately force: state IDLE, counter 0, shift register 0, rdata 32'h0, rdone 0, uart_arvalid 0, uart_rready 0, uart_araddr STAT_ADDR.
REQ-027 Reset mid-transaction SHALL abandon the word; partial bytes discarded; no rdone after release.

Verification
REQ-028 Bytes 8'h12,8'h34,8'h56,8'h78 available, status bit0=1, OKAY responses -> one rdone pulse, rdata=32'h12345678.
REQ-029 Status reads return 32'h0 three times before each byte -> exactly 4 reads at RX_ADDR, 16 at STAT_ADDR, rdata correct.
REQ-030 SLVERR (rresp=2'b10) on second RX_ADDR read, then OKAY -> byte not duplicated or skipped, rdata=32'h12345678.
REQ-031 arready held low 10 cycles -> arvalid and araddr stable throughout; renable pulses while busy -> exactly one rdone.
REQ-032 rstn asserted after two bytes, then new renable with bytes AA,BB,CC,DD -> rdata=32'hAABBCCDD, single rdone.
